// File: rtl/dv_tb_pkg.sv
// -----------------------------------------------------------------------------
// dv_tb_pkg
// Shared types and constants for the riscv-dv end-of-test monitor.
//   state_e        : monitor FSM states (IDLE, RUN, DONE)
//   RES_TRAP       : result code reported when the core traps
//   RES_TIMEOUT    : result code reported when the run budget expires
//   wstrb_to_mask  : expands 4 byte strobes into a 32-bit byte mask
// -----------------------------------------------------------------------------
package dv_tb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] RES_TRAP    = 32'hDEAD_0001;
  localparam logic [31:0] RES_TIMEOUT = 32'hDEAD_0002;

  // Each strobe bit enables the corresponding byte lane of the write data.
  function automatic logic [31:0] wstrb_to_mask(input logic [3:0] wstrb);
    logic [31:0] mask;
    mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    return mask;
  endfunction

endpackage

// File: rtl/dv_sig_accum.sv
// -----------------------------------------------------------------------------
// dv_sig_accum
// Rotate-XOR checksum over writes that land inside the signature window.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_en           : qualified write beat while the test is running
//   i_addr         : write byte address
//   i_wdata        : write data
//   i_wstrb        : byte strobes (masks the data folded into the checksum)
//   o_sig          : registered checksum
// -----------------------------------------------------------------------------
module dv_sig_accum
  import dv_tb_pkg::*;
#(
  parameter logic [31:0] SIG_BASE  = 32'h0000_2000,
  parameter int unsigned SIG_WORDS = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic [31:0] o_sig
);

  // Upper bound kept at 33 bits so a window touching the top of memory
  // does not wrap back to address 0.
  localparam logic [32:0] SIG_END = {1'b0, SIG_BASE} + 33'(SIG_WORDS * 4);

  logic        w_in_win;
  logic        w_upd;
  logic [31:0] w_sig_next;
  logic [31:0] r_sig;

  assign w_in_win   = ({1'b0, i_addr} >= {1'b0, SIG_BASE}) && ({1'b0, i_addr} < SIG_END);
  assign w_upd      = i_en && w_in_win;
  assign w_sig_next = {r_sig[30:0], r_sig[31]} ^ (i_wdata & wstrb_to_mask(i_wstrb));

  // Checksum register: cleared by reset, folds in each in-window write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sig <= 32'd0;
    end else if (w_upd) begin
      r_sig <= w_sig_next;
    end else begin
      r_sig <= r_sig;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/dv_test_monitor.sv
// -----------------------------------------------------------------------------
// dv_test_monitor
// End-of-test monitor for the PicoRV32 riscv-dv bench. Snoops the native
// memory bus and ends the test on a tohost write, a trap or a timeout.
// Ports:
//   i_clk, i_reset     : clock, synchronous active-high reset
//   i_test_start       : level, starts the run when seen high in IDLE
//   i_mem_valid/ready  : bus handshake; a beat with nonzero strobes is a write
//   i_mem_addr/wdata   : request byte address and write data
//   i_mem_wstrb        : byte strobes, 0 means read
//   i_trap             : core trap indication
//   o_test_done        : sticky end-of-test flag
//   o_test_pass        : pass/fail, meaningful when o_test_done=1
//   o_test_result      : result code (tohost data or DEAD_000x)
//   o_timeout          : sticky, test ended by timeout
//   o_cycle_count      : RUN cycles elapsed (saturating)
//   o_signature        : rotate-XOR checksum of signature-window writes
// -----------------------------------------------------------------------------
module dv_test_monitor
  import dv_tb_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter logic [31:0] SIG_BASE       = 32'h0000_2000,
  parameter int unsigned SIG_WORDS      = 64,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_test_start,
  input  logic             i_mem_valid,
  input  logic             i_mem_ready,
  input  logic [31:0]      i_mem_addr,
  input  logic [31:0]      i_mem_wdata,
  input  logic [3:0]       i_mem_wstrb,
  input  logic             i_trap,
  output logic             o_test_done,
  output logic             o_test_pass,
  output logic [31:0]      o_test_result,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic [31:0]      o_signature
);

  // Count value seen during the last allowed RUN cycle; unused when disabled.
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? {CNT_W{1'b0}} : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_e           r_state;
  state_e           w_state_next;
  logic             r_done;
  logic             r_pass;
  logic [31:0]      r_result;
  logic             r_timeout;
  logic [CNT_W-1:0] r_count;

  logic             w_done_next;
  logic             w_pass_next;
  logic [31:0]      w_result_next;
  logic             w_timeout_next;
  logic [CNT_W-1:0] w_count_next;

  logic             w_wr;
  logic             w_tohost;
  logic             w_to_hit;
  logic             w_run;

  assign w_wr     = i_mem_valid && i_mem_ready && (|i_mem_wstrb);
  assign w_tohost = w_wr && (i_mem_addr[31:2] == TOHOST_ADDR[31:2]);
  assign w_to_hit = TO_EN && (r_count == TO_LAST);
  assign w_run    = (r_state == RUN);

  // Next-state and next-output logic; everything holds unless changed below.
  always_comb begin
    w_state_next   = r_state;
    w_done_next    = r_done;
    w_pass_next    = r_pass;
    w_result_next  = r_result;
    w_timeout_next = r_timeout;
    w_count_next   = r_count;
    case (r_state)
      IDLE: begin
        w_count_next = {CNT_W{1'b0}};
        if (i_test_start) begin
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      RUN: begin
        // The count also advances on the ending edge, so a tohost write seen
        // with count N leaves the counter at N+1.
        if (r_count != {CNT_W{1'b1}}) begin
          w_count_next = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          w_count_next = r_count;
        end
        if (w_tohost) begin
          w_state_next  = DONE;
          w_done_next   = 1'b1;
          w_pass_next   = (i_mem_wdata == 32'd1);
          w_result_next = i_mem_wdata;
        end else if (i_trap) begin
          w_state_next  = DONE;
          w_done_next   = 1'b1;
          w_pass_next   = 1'b0;
          w_result_next = RES_TRAP;
        end else if (w_to_hit) begin
          w_state_next   = DONE;
          w_done_next    = 1'b1;
          w_pass_next    = 1'b0;
          w_result_next  = RES_TIMEOUT;
          w_timeout_next = 1'b1;
        end else begin
          w_state_next = RUN;
        end
      end
      DONE: begin
        w_state_next = DONE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State and status registers; reset aborts from any state on this edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_result  <= 32'd0;
      r_timeout <= 1'b0;
      r_count   <= {CNT_W{1'b0}};
    end else begin
      r_state   <= w_state_next;
      r_done    <= w_done_next;
      r_pass    <= w_pass_next;
      r_result  <= w_result_next;
      r_timeout <= w_timeout_next;
      r_count   <= w_count_next;
    end
  end

  dv_sig_accum #(
    .SIG_BASE  (SIG_BASE),
    .SIG_WORDS (SIG_WORDS)
  ) u_sig_accum (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (w_run && w_wr),
    .i_addr  (i_mem_addr),
    .i_wdata (i_mem_wdata),
    .i_wstrb (i_mem_wstrb),
    .o_sig   (o_signature)
  );

  assign o_test_done   = r_done;
  assign o_test_pass   = r_pass;
  assign o_test_result = r_result;
  assign o_timeout     = r_timeout;
  assign o_cycle_count = r_count;

endmodule

// File: tb/tb_dv_test_monitor.sv
// -----------------------------------------------------------------------------
// tb_dv_test_monitor
// Directed bench for dv_test_monitor with a 50-cycle timeout budget.
// -----------------------------------------------------------------------------
module tb_dv_test_monitor;

  logic        clk;
  logic        reset;
  logic        test_start;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        trap;
  logic        test_done;
  logic        test_pass;
  logic [31:0] test_result;
  logic        timeout;
  logic [31:0] cycle_count;
  logic [31:0] signature;

  int n_checks;
  int n_errors;

  dv_test_monitor #(
    .TOHOST_ADDR    (32'h0000_1000),
    .SIG_BASE       (32'h0000_2000),
    .SIG_WORDS      (64),
    .TIMEOUT_CYCLES (50),
    .CNT_W          (32)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_test_start  (test_start),
    .i_mem_valid   (mem_valid),
    .i_mem_ready   (mem_ready),
    .i_mem_addr    (mem_addr),
    .i_mem_wdata   (mem_wdata),
    .i_mem_wstrb   (mem_wstrb),
    .i_trap        (trap),
    .o_test_done   (test_done),
    .o_test_pass   (test_pass),
    .o_test_result (test_result),
    .o_timeout     (timeout),
    .o_cycle_count (cycle_count),
    .o_signature   (signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle 1 time unit so outputs are sampled off-edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_idle();
    mem_valid = 1'b0;
    mem_ready = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_wstrb = 4'd0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mem_valid = 1'b1;
    mem_ready = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic start_run();
    test_start = 1'b1;
    step(1);
    test_start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".done"},   {63'd0, test_done},   64'd0);
    check_eq({tag, ".pass"},   {63'd0, test_pass},   64'd0);
    check_eq({tag, ".result"}, {32'd0, test_result}, 64'd0);
    check_eq({tag, ".tmo"},    {63'd0, timeout},     64'd0);
    check_eq({tag, ".count"},  {32'd0, cycle_count}, 64'd0);
    check_eq({tag, ".sig"},    {32'd0, signature},   64'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    test_start = 1'b0;
    trap       = 1'b0;
    bus_idle();
    step(2);
    reset = 1'b0;
    check_all_zero("rst");

    // Bus write in IDLE must neither start the test nor touch the signature.
    bus_wr(32'h0000_2000, 32'hFFFF_FFFF, 4'hF);
    step(1);
    bus_wr(32'h0000_1000, 32'h0000_0001, 4'hF);
    step(1);
    bus_idle();
    step(1);
    check_all_zero("idle_bus");

    // Tohost pass after 10 RUN cycles.
    start_run();
    step(10);
    check_eq("run10.count", {32'd0, cycle_count}, 64'd10);
    check_eq("run10.done",  {63'd0, test_done},   64'd0);
    bus_wr(32'h0000_1000, 32'h0000_0001, 4'hF);
    step(1);
    bus_idle();
    check_eq("pass.done",   {63'd0, test_done},   64'd1);
    check_eq("pass.pass",   {63'd0, test_pass},   64'd1);
    check_eq("pass.result", {32'd0, test_result}, 64'd1);
    check_eq("pass.count",  {32'd0, cycle_count}, 64'd11);
    check_eq("pass.tmo",    {63'd0, timeout},     64'd0);

    // DONE ignores trap, start and in-window writes.
    trap       = 1'b1;
    test_start = 1'b1;
    bus_wr(32'h0000_2000, 32'h1234_5678, 4'hF);
    step(3);
    trap       = 1'b0;
    test_start = 1'b0;
    bus_idle();
    check_eq("frz.result", {32'd0, test_result}, 64'd1);
    check_eq("frz.count",  {32'd0, cycle_count}, 64'd11);
    check_eq("frz.sig",    {32'd0, signature},   64'd0);
    check_eq("frz.pass",   {63'd0, test_pass},   64'd1);

    // One-cycle reset in DONE clears everything.
    do_reset();
    check_all_zero("rst_done");

    // Tohost fail code 7 written on the first RUN cycle.
    start_run();
    bus_wr(32'h0000_1000, 32'h0000_0007, 4'hF);
    step(1);
    bus_idle();
    check_eq("fail7.done",   {63'd0, test_done},   64'd1);
    check_eq("fail7.pass",   {63'd0, test_pass},   64'd0);
    check_eq("fail7.result", {32'd0, test_result}, 64'd7);
    check_eq("fail7.count",  {32'd0, cycle_count}, 64'd1);

    // Timeout after 50 RUN cycles.
    do_reset();
    start_run();
    step(49);
    check_eq("tmo49.done",  {63'd0, test_done},   64'd0);
    check_eq("tmo49.count", {32'd0, cycle_count}, 64'd49);
    step(1);
    check_eq("tmo.done",   {63'd0, test_done},   64'd1);
    check_eq("tmo.pass",   {63'd0, test_pass},   64'd0);
    check_eq("tmo.result", {32'd0, test_result}, 64'h0000_0000_DEAD_0002);
    check_eq("tmo.tmo",    {63'd0, timeout},     64'd1);
    check_eq("tmo.count",  {32'd0, cycle_count}, 64'd50);
    step(5);
    check_eq("tmo.hold",   {32'd0, cycle_count}, 64'd50);

    // Tohost beats trap on the same edge.
    do_reset();
    start_run();
    step(2);
    trap = 1'b1;
    bus_wr(32'h0000_1000, 32'h0000_0001, 4'hF);
    step(1);
    trap = 1'b0;
    bus_idle();
    check_eq("prio.pass",   {63'd0, test_pass},   64'd1);
    check_eq("prio.result", {32'd0, test_result}, 64'd1);

    // Trap alone.
    do_reset();
    start_run();
    trap = 1'b1;
    step(1);
    trap = 1'b0;
    check_eq("trap.done",   {63'd0, test_done},   64'd1);
    check_eq("trap.pass",   {63'd0, test_pass},   64'd0);
    check_eq("trap.result", {32'd0, test_result}, 64'h0000_0000_DEAD_0001);
    check_eq("trap.tmo",    {63'd0, timeout},     64'd0);

    // Signature window accumulation.
    do_reset();
    start_run();
    bus_wr(32'h0000_2000, 32'hA5A5_A5A5, 4'hF);
    step(1);
    check_eq("sig1", {32'd0, signature}, 64'h0000_0000_A5A5_A5A5);
    bus_wr(32'h0000_2000, 32'h1234_56FF, 4'h1);
    step(1);
    check_eq("sig2", {32'd0, signature}, 64'h0000_0000_4B4B_4BB4);
    bus_wr(32'h0000_2100, 32'hFFFF_FFFF, 4'hF);
    step(1);
    check_eq("sig_oow", {32'd0, signature}, 64'h0000_0000_4B4B_4BB4);
    bus_wr(32'h0000_2004, 32'hFFFF_FFFF, 4'h0);
    step(1);
    mem_ready = 1'b0;
    mem_wstrb = 4'hF;
    step(1);
    check_eq("sig_rd_nordy", {32'd0, signature}, 64'h0000_0000_4B4B_4BB4);
    bus_wr(32'h0000_20FC, 32'h0000_0001, 4'hF);
    step(1);
    bus_idle();
    check_eq("sig_last", {32'd0, signature}, 64'h0000_0000_9696_9769);
    check_eq("sig.done", {63'd0, test_done}, 64'd0);

    // Mid-RUN reset aborts to IDLE; counter stays at 0 without a start.
    do_reset();
    check_all_zero("rst_run");
    step(3);
    check_eq("idle.count", {32'd0, cycle_count}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
